muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even and >= 4.
REQ-002 The block SHALL decode these funct codes: MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 funct  input  6  operation select.
REQ-008 rs_val  input  WIDTH  operand A: dividend, multiplicand, or MTHI/MTLO source.
REQ-009 rt_val  input  WIDTH  operand B: divisor or multiplier.
REQ-010 flush  input  1  abort the in-flight operation.
REQ-011 result  output  WIDTH  registered MFHI/MFLO read data.
REQ-012 result_valid  output  1  one-cycle pulse, result valid.
REQ-013 busy  output  1  multi-cycle operation in progress.
REQ-014 div_by_zero  output  1  one-cycle pulse at completion of a DIV/DIVU whose divisor was 0.
REQ-015 illegal  output  1  one-cycle pulse when an unsupported funct is accepted.
REQ-016 hi, lo  output  WIDTH each  current HI/LO architectural registers.

Function
REQ-017 Acceptance SHALL occur on any edge where in_valid && in_ready is true and flush is low.
REQ-018 in_ready SHALL be high only in state IDLE.
REQ-019 The FSM SHALL have states IDLE, MUL, DIV and FIX.
REQ-020 Accepting MULT or MULTU SHALL move IDLE to MUL; accepting DIV or DIVU SHALL move IDLE to DIV; all other funct values SHALL leave the FSM in IDLE.
REQ-021 MUL and DIV SHALL each last exactly WIDTH cycles, one iteration per cycle (shift-add multiply, restoring divide on magnitudes), then move to FIX.
REQ-022 FIX SHALL last 1 cycle for sign correction and the HI/LO write, then move to IDLE.
REQ-023 For acceptance at edge k, busy SHALL be high in cycles k+1..k+WIDTH+1, HI/LO SHALL update at edge k+WIDTH+1, and in_ready SHALL return high after that edge.
REQ-024 MULT/MULTU SHALL produce {hi,lo} = full 2*WIDTH-bit product (signed or unsigned respectively).
REQ-025 DIV/DIVU SHALL produce lo = quotient truncated toward zero and hi = remainder, with the remainder carrying the sign of the dividend for DIV.
REQ-026 For DIV of most-negative / -1, the block SHALL produce lo = most-negative and hi = 0, with no flag.
REQ-027 For a divisor of 0 (DIV or DIVU), the block SHALL produce hi = rs_val and lo = all ones, and pulse div_by_zero in the cycle after the FIX edge.
REQ-028 MTHI/MTLO SHALL write rs_val to hi/lo at the acceptance edge, with no result_valid.
REQ-029 MFHI/MFLO SHALL load result with the current hi/lo at the acceptance edge and pulse result_valid for the following cycle.
REQ-030 An MFHI/MFLO presented while busy SHALL be held off by in_ready = 0 (stall) and is therefore never served stale data.
REQ-031 An unsupported funct SHALL be accepted, pulse illegal for one cycle, and have no other effect.
REQ-032 flush in MUL, DIV or FIX SHALL return the FSM to IDLE at that edge, leave hi/lo unchanged, and produce no pulses.
REQ-033 flush and in_valid in the same cycle SHALL result in flush winning and the request not being accepted.
REQ-034 Operands SHALL be captured at acceptance; later changes on rs_val/rt_val SHALL have no effect on the in-flight operation.
REQ-035 Internal iteration counter width SHALL be $clog2(WIDTH)+1 bits.

Reset
REQ-036 When rst_n is low, regardless of clk, state SHALL be IDLE, hi = lo = result = 0, and busy = result_valid = div_by_zero = illegal = 0.
REQ-037 While rst_n is low, in_ready SHALL be 1.
REQ-038 Reset asserted mid-operation SHALL discard the operation; the first request after rst_n rises SHALL be acceptable on the first clock edge.

Verification (WIDTH=32)
REQ-039 MULT rs=0xFFFFFFFD, rt=7 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-040 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-041 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-042 DIVU 10/0 -> hi=0x0000000A, lo=0xFFFFFFFF, and a single-cycle div_by_zero pulse.
REQ-043 MFHI held with in_valid during a busy DIV -> not accepted until in_ready rises; then result = new hi with a one-cycle result_valid pulse.
REQ-044 flush at MUL iteration 10 -> hi/lo unchanged and in_ready=1 next cycle; separately, rst_n low mid-DIV -> hi=lo=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with a single FIX cycle that applies signs and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             div_by_zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic               illegal_q, illegal_d;

  logic               accept, op_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready && !flush;
  // in_ready is high exactly when the FSM is IDLE (including throughout reset).
  assign in_ready     = (state_q == S_IDLE);
  assign accept       = in_valid && in_ready && !flush;
  assign busy         = (state_q != S_IDLE);
  assign fsm_state    = state_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign div_by_zero  = div_by_zero_q;
  assign illegal      = illegal_q;

  assign op_signed = (funct == F_MULT) || (funct == F_DIV);
  assign mag_a     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign mag_b     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // p_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opr_q} : '0);
  assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opr_q};

  assign prod_fix = neg_lo_q ? -p_q : p_q;
  assign quo_fix  = neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    p_d            = p_q;
    opr_d          = opr_q;
    a_d            = a_q;
    is_div_d       = is_div_q;
    neg_lo_d       = neg_lo_q;
    neg_hi_d       = neg_hi_q;
    dbz_d          = dbz_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    div_by_zero_d  = 1'b0;
    illegal_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (funct)
            F_MULT, F_MULTU: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              p_d      = {{WIDTH{1'b0}}, mag_b};
              opr_d    = mag_a;
              is_div_d = 1'b0;
              neg_lo_d = op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_hi_d = 1'b0;
              dbz_d    = 1'b0;
            end
            F_DIV, F_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = '0;
              p_d      = {{WIDTH{1'b0}}, mag_a};
              opr_d    = mag_b;
              a_d      = rs_val;
              is_div_d = 1'b1;
              neg_lo_d = op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_hi_d = op_signed && rs_val[WIDTH-1];
              dbz_d    = (rt_val == '0);
            end
            F_MFHI: begin
              result_d       = hi_q;
              result_valid_d = 1'b1;
            end
            F_MFLO: begin
              result_d       = lo_q;
              result_valid_d = 1'b1;
            end
            F_MTHI:  hi_d = rs_val;
            F_MTLO:  lo_d = rs_val;
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          p_d   = {mul_sum, p_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!div_diff[WIDTH]) p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          else                  p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dbz_q) begin
            hi_d          = a_q;
            lo_d          = '1;
            div_by_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      p_q            <= '0;
      opr_q          <= '0;
      a_q            <= '0;
      is_div_q       <= 1'b0;
      neg_lo_q       <= 1'b0;
      neg_hi_q       <= 1'b0;
      dbz_q          <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      p_q            <= p_d;
      opr_q          <= opr_d;
      a_q            <= a_d;
      is_div_q       <= is_div_d;
      neg_lo_q       <= neg_lo_d;
      neg_hi_q       <= neg_hi_d;
      dbz_q          <= dbz_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      div_by_zero_q  <= div_by_zero_d;
      illegal_q      <= illegal_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit: HI/LO reference model built on plain 64-bit
// arithmetic, directed corner cases, stall/flush/reset scenarios.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic         clk, rst_n, in_valid, in_ready, flush;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val, result, hi, lo;
  logic         result_valid, busy, div_by_zero, illegal;
  logic [1:0]   fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .result(result), .result_valid(result_valid), .busy(busy),
    .div_by_zero(div_by_zero), .illegal(illegal), .hi(hi), .lo(lo),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO outcome of an arithmetic op from the architectural rules.
  function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    z = 1'b0;
    h = '0;
    l = '0;
    sa = a;
    sb = b;
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {h, l} = sp;
      end
      F_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {h, l} = up;
      end
      F_DIV, F_DIVU: begin
        if (b == 0) begin
          h = a;
          l = '1;
          z = 1'b1;
        end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = a;
          h = '0;
        end else if (f == F_DIV) begin
          l = sa / sb;
          h = sa % sb;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // driver: present a request at a negedge, return 1 time unit after its acceptance edge
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    funct    = f;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs_val   = $urandom;
    rt_val   = $urandom;
  endtask

  task automatic run_arith(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic         ez;
    int           nb;
    model(f, a, b, eh, el, ez);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    issue(f, a, b);
    nb = 0;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (i == W / 2) check("hi_held", hi, m_hi);
    end
    check("busy_cycles", nb, W + 1);
    @(negedge clk);
    check("busy_done", busy, 0);
    check("ready_back", in_ready, 1);
    check("hi", hi, exp_q.pop_front());
    check("lo", lo, exp_q.pop_front());
    check("dbz_pulse", div_by_zero, ez);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    check("dbz_clear", div_by_zero, 0);
  endtask

  task automatic run_mf(input bit is_hi);
    issue(is_hi ? F_MFHI : F_MFLO, $urandom, $urandom);
    @(negedge clk);
    check("rv_pulse", result_valid, 1);
    check("mf_result", result, is_hi ? m_hi : m_lo);
    @(negedge clk);
    check("rv_clear", result_valid, 0);
  endtask

  task automatic run_mt(input bit is_hi, input logic [W-1:0] a);
    issue(is_hi ? F_MTHI : F_MTLO, a, $urandom);
    if (is_hi) m_hi = a;
    else       m_lo = a;
    @(negedge clk);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    check("mt_no_rv", result_valid, 0);
    check("mt_not_busy", busy, 0);
  endtask

  task automatic run_illegal();
    logic [5:0] f;
    f = 6'(($urandom_range(0, 63)));
    while (f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO ||
           f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU)
      f = 6'(($urandom_range(0, 63)));
    issue(f, $urandom, $urandom);
    @(negedge clk);
    check("illegal_pulse", illegal, 1);
    check("illegal_hi", hi, m_hi);
    check("illegal_lo", lo, m_lo);
    check("illegal_busy", busy, 0);
    @(negedge clk);
    check("illegal_clear", illegal, 0);
  endtask

  initial begin
    logic [W-1:0] eh, el, a, b, v;
    logic         ez;
    int           stall, rvh, pulses;

    // reset
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; funct = '0; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0;
    #23;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_pulses", {result_valid, div_by_zero, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed corner cases
    run_arith(F_MULT,  32'hFFFF_FFFD, 32'd7);
    check("mult_neg_hi", m_hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", m_lo, 32'hFFFF_FFEB);
    run_arith(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_arith(F_DIV,   32'hFFFF_FFF9, 32'd2);
    run_arith(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_arith(F_DIVU,  32'd10, 32'd0);
    run_arith(F_DIV,   32'hFFFF_FFF0, 32'd0);
    run_mf(1'b1);
    run_mf(1'b0);
    run_mt(1'b1, 32'h1234_5678);
    run_mt(1'b0, 32'h9ABC_DEF0);
    run_illegal();

    // MFHI held against a busy DIV
    a = 32'd1000; b = 32'hFFFF_FFF9;
    model(F_DIV, a, b, eh, el, ez);
    issue(F_DIV, a, b);
    in_valid = 1'b1; funct = F_MFHI;
    stall = 0; rvh = 0;
    @(negedge clk);
    while (!in_ready && stall < 200) begin
      stall++;
      if (result_valid) rvh++;
      @(negedge clk);
    end
    check("mf_stall_cycles", stall, W + 1);
    check("mf_no_stale_rv", rvh, 0);
    check("mf_hi_new", hi, eh);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_hi = eh; m_lo = el;
    @(negedge clk);
    check("mf_stall_rv", result_valid, 1);
    check("mf_stall_result", result, eh);
    @(negedge clk);
    check("mf_stall_rv_clear", result_valid, 0);

    // flush during MUL
    issue(F_MULT, $urandom, $urandom);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    pulses = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (result_valid || div_by_zero || illegal || hi != m_hi || lo != m_lo) pulses++;
    end
    check("flush_quiet", pulses, 0);

    // flush in FIX of a divide-by-zero
    issue(F_DIVU, $urandom, 32'd0);
    repeat (W + 1) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flushfix_dbz", div_by_zero, 0);
    check("flushfix_hi", hi, m_hi);
    check("flushfix_lo", lo, m_lo);
    check("flushfix_ready", in_ready, 1);

    // flush beats a simultaneous request
    @(negedge clk);
    in_valid = 1'b1; funct = F_MTHI; rs_val = ~m_hi; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_wins_hi", hi, m_hi);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 20));
      case ($urandom_range(0, 8))
        0: run_arith(F_MULT, a, b);
        1: run_arith(F_MULTU, a, b);
        2: run_arith(F_DIV, a, b);
        3: run_arith(F_DIVU, a, b);
        4: run_mt(1'b1, a);
        5: run_mt(1'b0, a);
        6: run_mf(1'b1);
        7: run_mf(1'b0);
        default: run_illegal();
      endcase
    end

    // reset mid-DIV, then a request on the very first edge after release
    issue(F_DIV, $urandom, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    v = $urandom;
    in_valid = 1'b1; funct = F_MTLO; rs_val = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_lo = v;
    @(negedge clk);
    check("post_rst_accept", lo, v);
    check("post_rst_hi", hi, 0);
    run_mf(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
